z80_bus_responder: RTL and testbench
====================================

// Module: z80_bus_responder
// PURPOSE
//  Parametrised memory + I/O slave for the tv80s CPU test benches.
//  - Serves memory and I/O cycles and inserts programmable wait states.
//  - Commits writes exactly once per bus cycle and logs every committed write in a FIFO.
//  - Counts opcode fetches, so directed instruction tests can check bus traffic as well as final state.
//  - Sits between the CPU bus pins and the bench; contents are preloaded and inspected through hierarchical mem[]/io[] access.
// PARAMETERS
//  MEM_AW     16  memory address width; mem[] has 2**MEM_AW bytes, indexed by A[MEM_AW-1:0]
//  IO_AW      8   I/O address width; io[] has 2**IO_AW bytes, indexed by A[IO_AW-1:0]
//  MEM_WAIT   0   wait states added to each memory read/write cycle (0..15)
//  IO_WAIT    0   wait states added to each I/O cycle, on top of the CPU's built-in one (0..15)
//  LOG_DEPTH  16  write-log FIFO depth; must be a power of 2, >=2
// PORTS
//  clk        in   1   CPU clock; all state changes on posedge
//  reset_n    in   1   asynchronous, active-low reset
//  A          in   16  CPU address bus
//  dout       in   8   CPU write data
//  mreq_n     in   1   memory request
//  iorq_n     in   1   I/O request
//  rd_n       in   1   read strobe
//  wr_n       in   1   write strobe
//  m1_n       in   1   M1 cycle
//  rfsh_n     in   1   refresh cycle
//  di         out  8   read data to CPU (registered)
//  wait_n     out  1   wait request to CPU (registered)
//  log_pop    in   1   consume log head; ignored when log_valid=0
//  log_valid  out  1   log FIFO non-empty
//  log_addr   out  16  head entry address
//  log_data   out  8   head entry data
//  log_io     out  1   head entry kind: 1=I/O write, 0=memory write
//  log_ovf    out  1   sticky: a write was dropped because the FIFO was full
//  m1_count   out  32  opcode fetches since reset
// BEHAVIOUR
//  Reset: di=00, wait_n=1, log empty (log_valid=0, log_addr/data/io=0), log_ovf=0, m1_count=0, FSM IDLE.
//    mem[]/io[] are not cleared.
//  Strobes are sampled at posedge:
//    mem_acc = !mreq_n && rfsh_n
//    io_acc  = !iorq_n && m1_n  (an interrupt-acknowledge cycle is not an access)
//  FSM states: IDLE, WAIT, ACTIVE, DONE.
//    IDLE->WAIT: an access is seen and the loaded wait count n>0.
//      n=MEM_WAIT for mem_acc, IO_WAIT for io_acc.
//      wait_n=0 for exactly n clocks, then the FSM moves to ACTIVE.
//    IDLE->ACTIVE: an access is seen and n=0.
//    ACTIVE->DONE: the write is committed (see below).
//    ACTIVE/DONE->IDLE: mreq_n=1 and iorq_n=1.
//    In WAIT, dropping the strobe aborts to IDLE with no commit.
//  wait_n is driven low only in WAIT; it is high in every other state.
//  Read data:
//    di <= io[A] if !iorq_n, else mem[A], every clock.
//    Read latency is 1 clock, independent of rd_n.
//  Write commit:
//    Happens in ACTIVE with !wr_n.
//    Sets mem[A] or io[A] to dout, pushes {A, dout, io} to the log, then moves to DONE.
//    Exactly one commit per bus cycle, even if wr_n stays low for several clocks.
//  Refresh cycles (mreq_n=0, rfsh_n=0): never stalled, never written, never counted.
//  m1_count increments by 1 on the first clock of each mem_acc with !m1_n.
//    Wraps from FFFF_FFFF to 0.
//  Log FIFO:
//    First-word fall-through; head is valid whenever log_valid=1.
//    Push when full: the entry is dropped, log_ovf<=1, and the memory write still happens.
//    Push and pop in the same clock when full: both take effect and nothing is dropped.
//    Push and pop in the same clock when empty: the push lands and log_valid=1 next clock.
//    log_ovf is cleared only by reset.
//  reset_n low mid-access: the FSM returns to IDLE, wait_n=1 and the log is flushed.
//    A commit happens only if it already took effect before the reset edge.
// TESTING
//  1 MEM_WAIT=0: preload C4 61 9C @0000 (CALL NZ), SP=5698.
//    -> m1_count=1, log holds {5697,00,0} then {5696,03,0}, mem[5696..5697]=03 00.
//  2 MEM_WAIT=2: one LD (HL),A with HL=4000, A=5A.
//    -> wait_n low for exactly 2 clocks on each memory cycle, one log entry {4000,5A,0}, mem[4000]=5A.
//  3 IO_WAIT=1: OUT (7F),A with A=33.
//    -> io[7F]=33, log entry {007F or 337F per A bus,33,1}, wait_n low 1 clock.
//    IN A,(7F) -> A=33.
//  4 LOG_DEPTH=4, no pops, 5 memory writes.
//    -> log_valid=1, 4 entries retained in order, log_ovf=1, all 5 bytes present in mem[].
//  5 Log full, log_pop and a write in the same clock.
//    -> entry count stays 4, head advances, log_ovf stays 0.
//  6 reset_n pulsed low while wait_n=0 (MEM_WAIT=3).
//    -> wait_n=1, log_valid=0, m1_count=0 immediately; no write to the target address.

Source files
------------

// File: rtl/z80_bus_responder.sv
// Memory + I/O slave for Z80 (tv80s) benches: wait-state insertion, single-commit writes,
// a first-word-fall-through write log and an opcode-fetch counter.
module z80_bus_responder #(
    parameter int MEM_AW    = 16,
    parameter int IO_AW     = 8,
    parameter int MEM_WAIT  = 0,
    parameter int IO_WAIT   = 0,
    parameter int LOG_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] A,
    input  logic [7:0]  dout,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic        rfsh_n,
    output logic [7:0]  di,
    output logic        wait_n,
    input  logic        log_pop,
    output logic        log_valid,
    output logic [15:0] log_addr,
    output logic [7:0]  log_data,
    output logic        log_io,
    output logic        log_ovf,
    output logic [31:0] m1_count
);
    localparam int LPW = $clog2(LOG_DEPTH);
    localparam int LW  = 25;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE, S_DONE} state_t;

    logic [7:0]    mem [0:(2**MEM_AW)-1];
    logic [7:0]    io  [0:(2**IO_AW)-1];
    logic [LW-1:0] log_mem [0:LOG_DEPTH-1];

    state_t       state_reg, state_next;
    logic [3:0]   cnt_reg, cnt_next;
    logic         io_cyc_reg, io_cyc_next;
    logic [LPW:0] wptr_reg, rptr_reg;
    logic [LPW:0] log_count;
    logic [LW-1:0] log_head;
    logic [3:0]   wait_load;
    logic         mem_acc, io_acc, released;
    logic         commit, m1_inc, log_full, pop_ok, push_ok;

    // rd_n is deliberately ignored: read data is presented every clock
    logic unused_ok;
    assign unused_ok = &{1'b0, rd_n, A};

    assign mem_acc   = !mreq_n && rfsh_n;
    assign io_acc    = !iorq_n && m1_n;
    assign released  = mreq_n && iorq_n;
    assign wait_load = mem_acc ? 4'(MEM_WAIT) : 4'(IO_WAIT);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        io_cyc_next = io_cyc_reg;
        commit      = 1'b0;
        m1_inc      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (mem_acc || io_acc) begin
                    io_cyc_next = !mem_acc;
                    m1_inc      = mem_acc && !m1_n;
                    if (wait_load != 4'd0) begin
                        state_next = S_WAIT;
                        cnt_next   = wait_load;
                    end else begin
                        state_next = S_ACTIVE;
                    end
                end
            end
            S_WAIT: begin
                if (released)
                    state_next = S_IDLE;
                else if (cnt_reg == 4'd1)
                    state_next = S_ACTIVE;
                else
                    cnt_next = cnt_reg - 4'd1;
            end
            S_ACTIVE: begin
                if (released) begin
                    state_next = S_IDLE;
                end else if (!wr_n) begin
                    commit     = 1'b1;
                    state_next = S_DONE;
                end
            end
            default: begin
                if (released)
                    state_next = S_IDLE;
            end
        endcase
    end

    assign log_count = wptr_reg - rptr_reg;
    assign log_full  = (log_count == (LPW+1)'(LOG_DEPTH));
    assign log_valid = (log_count != '0);
    assign pop_ok    = log_pop && log_valid;
    // a full log still accepts a push when the head leaves in the same clock
    assign push_ok   = commit && (!log_full || pop_ok);

    assign log_head = log_mem[rptr_reg[LPW-1:0]];
    assign log_addr = log_valid ? log_head[24:9] : 16'h0000;
    assign log_data = log_valid ? log_head[8:1]  : 8'h00;
    assign log_io   = log_valid ? log_head[0]    : 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= 4'd0;
            io_cyc_reg <= 1'b0;
            wait_n     <= 1'b1;
            di         <= 8'h00;
            m1_count   <= 32'd0;
            wptr_reg   <= '0;
            rptr_reg   <= '0;
            log_ovf    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            io_cyc_reg <= io_cyc_next;
            wait_n     <= (state_next != S_WAIT);
            di         <= !iorq_n ? io[A[IO_AW-1:0]] : mem[A[MEM_AW-1:0]];
            if (m1_inc)
                m1_count <= m1_count + 32'd1;
            if (push_ok)
                wptr_reg <= wptr_reg + 1'b1;
            if (pop_ok)
                rptr_reg <= rptr_reg + 1'b1;
            if (commit && !push_ok)
                log_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && !io_cyc_reg)
            mem[A[MEM_AW-1:0]] <= dout;
        if (commit && io_cyc_reg)
            io[A[IO_AW-1:0]] <= dout;
        if (push_ok)
            log_mem[wptr_reg[LPW-1:0]] <= {A, dout, io_cyc_reg};
    end
endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: emulated Z80 bus cycles, a transaction-level
// reference model compared every clock, and literal checks pinning the model.
module tb_z80_bus_responder;
    localparam int MEM_WAIT  = 2;
    localparam int IO_WAIT   = 1;
    localparam int LOG_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] A;
    logic [7:0]  dout;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
    logic [7:0]  di;
    logic        wait_n;
    logic        log_pop;
    logic        log_valid;
    logic [15:0] log_addr;
    logic [7:0]  log_data;
    logic        log_io;
    logic        log_ovf;
    logic [31:0] m1_count;

    z80_bus_responder #(
        .MEM_AW(16), .IO_AW(8), .MEM_WAIT(MEM_WAIT), .IO_WAIT(IO_WAIT), .LOG_DEPTH(LOG_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .A(A), .dout(dout), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n), .di(di), .wait_n(wait_n),
        .log_pop(log_pop), .log_valid(log_valid), .log_addr(log_addr), .log_data(log_data),
        .log_io(log_io), .log_ovf(log_ovf), .m1_count(m1_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory images, log queue and a per-bus-cycle view of the access
    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
        logic        io;
    } ent_t;

    logic [7:0]  m_mem [0:65535];
    logic [7:0]  m_io  [0:255];
    ent_t        m_q[$];
    logic [7:0]  e_di;
    bit          e_wait_n;
    bit          e_ovf;
    logic [31:0] e_m1;
    bit          in_cyc, cyc_io, done_wr;
    int          waits_left;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_q.delete();
                e_di = 8'h00; e_wait_n = 1'b1; e_ovf = 1'b0; e_m1 = 32'd0;
                in_cyc = 1'b0; done_wr = 1'b0; waits_left = 0; cyc_io = 1'b0;
            end else begin
                bit ma, ia, rel, pop, wr;
                logic [7:0] nd;
                ma  = !mreq_n && rfsh_n;
                ia  = !iorq_n && m1_n;
                rel = mreq_n && iorq_n;
                pop = log_pop && (m_q.size() > 0);
                wr  = 1'b0;
                nd  = !iorq_n ? m_io[A[7:0]] : m_mem[A];
                if (!in_cyc) begin
                    if (ma || ia) begin
                        in_cyc = 1'b1;
                        cyc_io = !ma;
                        waits_left = ma ? MEM_WAIT : IO_WAIT;
                        done_wr = 1'b0;
                        if (ma && !m1_n) e_m1 = e_m1 + 32'd1;
                    end
                end else if (rel) begin
                    in_cyc = 1'b0;
                end else if (waits_left > 0) begin
                    waits_left--;
                end else if (!done_wr && !wr_n) begin
                    wr = 1'b1;
                    done_wr = 1'b1;
                end
                if (pop) void'(m_q.pop_front());
                if (wr) begin
                    if (cyc_io) m_io[A[7:0]] = dout;
                    else m_mem[A] = dout;
                    if (m_q.size() < LOG_DEPTH) m_q.push_back('{a: A, d: dout, io: cyc_io});
                    else e_ovf = 1'b1;
                end
                e_di = nd;
                e_wait_n = !(in_cyc && waits_left > 0);
            end
        end
    end

    // Every-cycle compare of all outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && check_en) begin
                chk("di", di, e_di);
                chk("wait_n", wait_n, e_wait_n);
                chk("m1_count", m1_count, e_m1);
                chk("log_ovf", log_ovf, e_ovf);
                chk("log_valid", log_valid, m_q.size() > 0);
                chk("log_addr", log_addr, m_q.size() > 0 ? m_q[0].a : 16'h0);
                chk("log_data", log_data, m_q.size() > 0 ? m_q[0].d : 8'h0);
                chk("log_io", log_io, m_q.size() > 0 ? m_q[0].io : 1'b0);
            end
        end
    end

    task automatic setb(input logic [15:0] addr, input logic [7:0] val);
        dut.mem[addr] = val;
        m_mem[addr] = val;
    endtask

    task automatic bus(input bit io, input bit wr, input bit m1, input logic [15:0] addr,
                       input logic [7:0] data, input int hold, input bit pop_commit,
                       output logic [7:0] rdata, output int lows);
        int k;
        lows = 0;
        k = 0;
        @(negedge clk);
        A = addr; dout = data; m1_n = !m1;
        if (io) iorq_n = 1'b0; else mreq_n = 1'b0;
        if (wr) wr_n = 1'b0; else rd_n = 1'b0;
        do begin
            @(negedge clk);
            k++;
            if (!wait_n) lows++;
        end while (!wait_n && k < 40);
        chk("wait_release", wait_n, 1'b1);
        if (pop_commit) log_pop = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            log_pop = 1'b0;
        end
        rdata = di;
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
        if (m1) begin
            @(negedge clk);
            mreq_n = 1'b0; rfsh_n = 1'b0;
            @(negedge clk);
            mreq_n = 1'b1; rfsh_n = 1'b1;
        end
        $display("[TB] %s %s A=%04h d=%02h waits=%0d", io ? "io " : "mem", wr ? "wr" : (m1 ? "m1" : "rd"),
                 addr, wr ? data : rdata, lows);
    endtask

    task automatic pop();
        @(negedge clk);
        log_pop = 1'b1;
        @(negedge clk);
        log_pop = 1'b0;
    endtask

    logic [7:0] r;
    int lw;

    initial begin
        reset_n = 1'b0;
        A = 16'h0; dout = 8'h0; log_pop = 1'b0;
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            dut.mem[i] = 8'(i) ^ 8'(i >> 8);
            m_mem[i]   = 8'(i) ^ 8'(i >> 8);
        end
        for (int i = 0; i < 256; i++) begin
            dut.io[i] = ~8'(i);
            m_io[i]   = ~8'(i);
        end
        repeat (3) @(negedge clk);
        chk("rst_di", di, 8'h00);
        chk("rst_wait_n", wait_n, 1'b1);
        chk("rst_log_valid", log_valid, 1'b0);
        chk("rst_log_addr", log_addr, 16'h0);
        chk("rst_log_ovf", log_ovf, 1'b0);
        chk("rst_m1_count", m1_count, 32'd0);
        reset_n = 1'b1;
        check_en = 1'b1;

        // CALL NZ,9C61 with SP=5698: fetch, two operand reads, push 0003
        setb(16'h0000, 8'hC4); setb(16'h0001, 8'h61); setb(16'h0002, 8'h9C);
        bus(0, 0, 1, 16'h0000, 8'h00, 1, 0, r, lw);
        chk("t1_opcode", r, 8'hC4);
        chk("t1_fetch_waits", lw, 2);
        bus(0, 0, 0, 16'h0001, 8'h00, 1, 0, r, lw);
        chk("t1_lo", r, 8'h61);
        bus(0, 0, 0, 16'h0002, 8'h00, 1, 0, r, lw);
        chk("t1_hi", r, 8'h9C);
        bus(0, 1, 0, 16'h5697, 8'h00, 1, 0, r, lw);
        bus(0, 1, 0, 16'h5696, 8'h03, 1, 0, r, lw);
        chk("t1_m1_count", m1_count, 32'd1);
        chk("t1_head0", {log_addr, log_data, 7'd0, log_io}, {16'h5697, 8'h00, 8'h00});
        pop();
        chk("t1_head1", {log_addr, log_data, 7'd0, log_io}, {16'h5696, 8'h03, 8'h00});
        pop();
        chk("t1_empty", log_valid, 1'b0);
        chk("t1_mem", {dut.mem[16'h5696], dut.mem[16'h5697]}, 16'h0300);

        // LD (HL),A with HL=4000, A=5A
        setb(16'h0100, 8'h77);
        bus(0, 0, 1, 16'h0100, 8'h00, 1, 0, r, lw);
        chk("t2_opcode", r, 8'h77);
        bus(0, 1, 0, 16'h4000, 8'h5A, 1, 0, r, lw);
        chk("t2_write_waits", lw, 2);
        chk("t2_head", {log_addr, log_data, 7'd0, log_io}, {16'h4000, 8'h5A, 8'h00});
        chk("t2_mem", dut.mem[16'h4000], 8'h5A);
        chk("t2_m1_count", m1_count, 32'd2);
        pop();
        // wr_n held low for several clocks still commits once
        bus(0, 1, 0, 16'h4001, 8'hA5, 4, 0, r, lw);
        chk("t2_held_data", log_data, 8'hA5);
        pop();
        chk("t2_single_commit", log_valid, 1'b0);

        // OUT (7F),A then IN A,(7F) with A=33
        setb(16'h0200, 8'hD3); setb(16'h0201, 8'h7F);
        bus(0, 0, 1, 16'h0200, 8'h00, 1, 0, r, lw);
        bus(0, 0, 0, 16'h0201, 8'h00, 1, 0, r, lw);
        bus(1, 1, 0, 16'h337F, 8'h33, 1, 0, r, lw);
        chk("t3_io_waits", lw, 1);
        chk("t3_head", {log_addr, log_data, 7'd0, log_io}, {16'h337F, 8'h33, 8'h01});
        chk("t3_io", dut.io[8'h7F], 8'h33);
        pop();
        setb(16'h0202, 8'hDB); setb(16'h0203, 8'h7F);
        bus(0, 0, 1, 16'h0202, 8'h00, 1, 0, r, lw);
        bus(0, 0, 0, 16'h0203, 8'h00, 1, 0, r, lw);
        bus(1, 0, 0, 16'h337F, 8'h00, 1, 0, r, lw);
        chk("t3_in", r, 8'h33);
        chk("t3_m1_count", m1_count, 32'd4);
        // interrupt acknowledge is not an access: no stall, no count
        @(negedge clk);
        iorq_n = 1'b0; m1_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("inta_wait_n", wait_n, 1'b1);
        end
        iorq_n = 1'b1; m1_n = 1'b1;
        @(negedge clk);
        chk("inta_m1_count", m1_count, 32'd4);
        $display("[TB] io inta (no access)");

        // five writes into a four-entry log with no pops
        for (int i = 0; i < 5; i++)
            bus(0, 1, 0, 16'h5000 + 16'(i), 8'(8'h11 * (i + 1)), 1, 0, r, lw);
        chk("t4_ovf", log_ovf, 1'b1);
        chk("t4_mem_last", dut.mem[16'h5004], 8'h55);
        for (int i = 0; i < 4; i++) begin
            chk("t4_order", {log_addr, log_data}, {16'h5000 + 16'(i), 8'(8'h11 * (i + 1))});
            pop();
        end
        chk("t4_drained", log_valid, 1'b0);

        // reset pulse in the middle of a stalled write
        bus(0, 1, 0, 16'h6100, 8'h99, 1, 0, r, lw);
        @(negedge clk);
        A = 16'h6000; dout = 8'h77; mreq_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        chk("t6_stalled", wait_n, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_wait_n", wait_n, 1'b1);
        chk("t6_log_valid", log_valid, 1'b0);
        chk("t6_m1_count", m1_count, 32'd0);
        chk("t6_ovf", log_ovf, 1'b0);
        @(negedge clk);
        mreq_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        chk("t6_no_write", dut.mem[16'h6000], 8'h60);
        $display("[TB] mem wr A=6000 aborted by reset");

        // full log: pop and push in the same clock
        for (int i = 0; i < 4; i++)
            bus(0, 1, 0, 16'h7000 + 16'(i), 8'hA0 + 8'(i), 1, 0, r, lw);
        chk("t5_full_no_ovf", log_ovf, 1'b0);
        bus(0, 1, 0, 16'h7004, 8'hA4, 1, 1, r, lw);
        chk("t5_ovf", log_ovf, 1'b0);
        chk("t5_mem", dut.mem[16'h7004], 8'hA4);
        for (int i = 1; i < 5; i++) begin
            chk("t5_order", {log_addr, log_data}, {16'h7000 + 16'(i), 8'hA0 + 8'(i)});
            pop();
        end
        chk("t5_drained", log_valid, 1'b0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
